// File: rtl/tlbflushseq_pkg.sv
// Shared types for the TLB shootdown sequencer and the MMUs that consume its
// flush commands: configuration record, flush-kind encoding and FSM states.
package tlbflushseq_pkg;

  typedef struct packed {
    int unsigned XLEN;
    int unsigned ASID_BITS;
    int unsigned VMID_BITS;
    logic        H_SUPPORTED;
  } cvw_t;

  localparam cvw_t CVW_DEFAULT = '{XLEN: 64, ASID_BITS: 16, VMID_BITS: 14, H_SUPPORTED: 1'b1};

  typedef enum logic [1:0] {
    FLUSH_S  = 2'b00,
    FLUSH_VS = 2'b01,
    FLUSH_G  = 2'b10
  } flush_kind_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } fence_state_e;

endpackage

// File: rtl/tlbflushseq_if.sv
// Flush command bus between the shootdown sequencer (master) and the
// ITLB/DTLB (slave): per-TLB req/ack pairs plus the shared flush operands.
interface tlbflushseq_if import tlbflushseq_pkg::*; #(
  parameter cvw_t P = CVW_DEFAULT
) ();
  logic                   ITLBFlushReq;
  logic                   DTLBFlushReq;
  logic                   ITLBFlushAck;
  logic                   DTLBFlushAck;
  flush_kind_e            FlushKind;
  logic [P.XLEN-1:0]      FlushVAddr;
  logic                   FlushAllAddr;
  logic [P.ASID_BITS-1:0] FlushAsid;
  logic                   FlushAllAsid;
  logic [P.VMID_BITS-1:0] FlushVmid;

  modport master (
    output ITLBFlushReq, DTLBFlushReq, FlushKind, FlushVAddr, FlushAllAddr,
           FlushAsid, FlushAllAsid, FlushVmid,
    input  ITLBFlushAck, DTLBFlushAck
  );

  modport slave (
    input  ITLBFlushReq, DTLBFlushReq, FlushKind, FlushVAddr, FlushAllAddr,
           FlushAsid, FlushAllAsid, FlushVmid,
    output ITLBFlushAck, DTLBFlushAck
  );
endinterface

// File: rtl/tlbflushseq_hs.sv
// tlbflushhs: per-TLB flush request tracker.
//   clk, reset  clock, async active-low reset
//   start       launch a request (sequencer accepting a fence)
//   ack         one-cycle acknowledge from the TLB
//   req         request to the TLB; doubles as the pending flag
//   pending_d   pending flag as it will be next cycle
module tlbflushhs (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack,
  output logic req,
  output logic pending_d
);
  logic req_q, req_d;

  // An ack sampled while pending clears the request on the following cycle.
  always_comb begin
    req_d = start | (req_q & ~ack);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) req_q <= 1'b0;
    else        req_q <= req_d;
  end

  assign req       = req_q;
  assign pending_d = req_d;
endmodule

// File: rtl/tlbflushseq.sv
// tlbflushseq: sequences ITLB/DTLB shootdowns for sfence.vma / hfence.vvma /
// hfence.gvma reaching the M stage, stalling M until both TLBs acknowledge.
//   clk, reset              clock, async active-low reset
//   StallM, FlushM          M-stage stall / flush from other sources
//   sfencevmaM, hfence*M    decoded fence in M
//   InstrM                  instruction bits [24:15] (rs2, rs1)
//   SrcAM, SrcBM            rs1 / rs2 operand values
//   VirtModeW, HGATP_VMID   virtualisation mode and current VMID
//   tlb                     flush command bus to the TLBs (master side)
//   FenceStallM             hold M while a shootdown is in progress
//   FenceDoneM              shootdown complete, fence may retire
module tlbflushseq import tlbflushseq_pkg::*; #(
  parameter cvw_t P = CVW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   StallM,
  input  logic                   FlushM,
  input  logic                   sfencevmaM,
  input  logic                   hfencevvmaM,
  input  logic                   hfencegvmaM,
  input  logic [9:0]             InstrM,
  input  logic [P.XLEN-1:0]      SrcAM,
  input  logic [P.XLEN-1:0]      SrcBM,
  input  logic                   VirtModeW,
  input  logic [P.VMID_BITS-1:0] HGATP_VMID,
  tlbflushseq_if.master          tlb,
  output logic                   FenceStallM,
  output logic                   FenceDoneM
);
  fence_state_e           state_q, state_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  flush_kind_e            kind_q, kind_d, kind_sel;
  logic [P.XLEN-1:0]      vaddr_q, vaddr_d;
  logic                   all_addr_q, all_addr_d;
  logic [P.ASID_BITS-1:0] asid_q, asid_d;
  logic                   all_asid_q, all_asid_d;
  logic [P.VMID_BITS-1:0] vmid_q, vmid_d, vmid_sel;
  logic                   fence_m, accept, aborting;
  logic                   i_pend_d, d_pend_d;
  logic                   unused_srcb;

  assign unused_srcb = ^SrcBM;

  tlbflushhs u_itlb_hs (
    .clk(clk), .reset(reset), .start(accept), .ack(tlb.ITLBFlushAck),
    .req(tlb.ITLBFlushReq), .pending_d(i_pend_d)
  );

  tlbflushhs u_dtlb_hs (
    .clk(clk), .reset(reset), .start(accept), .ack(tlb.DTLBFlushAck),
    .req(tlb.DTLBFlushReq), .pending_d(d_pend_d)
  );

  always_comb begin
    fence_m  = sfencevmaM | (P.H_SUPPORTED & (hfencevvmaM | hfencegvmaM));
    accept   = (state_q == S_IDLE) & fence_m & ~FlushM;
    aborting = abort_q | FlushM;

    // gvma > vvma > sfence; sfence from VS/VU mode targets the VS stage.
    if (P.H_SUPPORTED && hfencegvmaM) begin
      kind_sel = FLUSH_G;
      vmid_sel = SrcBM[P.VMID_BITS-1:0];
    end else if (P.H_SUPPORTED && (hfencevvmaM || VirtModeW)) begin
      kind_sel = FLUSH_VS;
      vmid_sel = HGATP_VMID;
    end else begin
      kind_sel = FLUSH_S;
      vmid_sel = '0;
    end

    state_d    = state_q;
    done_d     = 1'b0;
    abort_d    = abort_q;
    kind_d     = kind_q;
    vaddr_d    = vaddr_q;
    all_addr_d = all_addr_q;
    asid_d     = asid_q;
    all_asid_d = all_asid_q;
    vmid_d     = vmid_q;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (accept) begin
          state_d    = S_REQ;
          kind_d     = kind_sel;
          vaddr_d    = SrcAM;
          all_addr_d = (InstrM[4:0] == 5'd0);
          asid_d     = SrcBM[P.ASID_BITS-1:0];
          all_asid_d = (InstrM[9:5] == 5'd0);
          vmid_d     = vmid_sel;
        end
      end
      S_REQ: begin
        abort_d = aborting;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A flushed fence still completes the handshake but never reports done.
        abort_d = aborting;
        if (!i_pend_d && !d_pend_d) begin
          state_d = aborting ? S_IDLE : S_DONE;
          done_d  = ~aborting;
        end
      end
      S_DONE: begin
        if (FlushM || !StallM) state_d = S_IDLE;
        else                   done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      kind_q     <= FLUSH_S;
      vaddr_q    <= '0;
      all_addr_q <= 1'b0;
      asid_q     <= '0;
      all_asid_q <= 1'b0;
      vmid_q     <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      kind_q     <= kind_d;
      vaddr_q    <= vaddr_d;
      all_addr_q <= all_addr_d;
      asid_q     <= asid_d;
      all_asid_q <= all_asid_d;
      vmid_q     <= vmid_d;
    end
  end

  always_comb begin
    FenceStallM = accept | (state_q == S_REQ) | (state_q == S_WAIT);
  end

  assign FenceDoneM       = done_q;
  assign tlb.FlushKind    = kind_q;
  assign tlb.FlushVAddr   = vaddr_q;
  assign tlb.FlushAllAddr = all_addr_q;
  assign tlb.FlushAsid    = asid_q;
  assign tlb.FlushAllAsid = all_asid_q;
  assign tlb.FlushVmid    = vmid_q;
endmodule

// File: tb/tb_tlbflushseq.sv
module tb_tlbflushseq;
  import tlbflushseq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallM, FlushM, sfencevmaM, hfencevvmaM, hfencegvmaM, VirtModeW;
  logic [9:0]  InstrM;
  logic [63:0] SrcAM, SrcBM;
  logic [13:0] HGATP_VMID;
  logic        FenceStallM, FenceDoneM;
  int          n_cmp = 0;
  int          n_err = 0;

  tlbflushseq_if #(.P(CVW_DEFAULT)) tlb ();

  tlbflushseq #(.P(CVW_DEFAULT)) dut (
    .clk(clk), .reset(reset), .StallM(StallM), .FlushM(FlushM),
    .sfencevmaM(sfencevmaM), .hfencevvmaM(hfencevvmaM), .hfencegvmaM(hfencegvmaM),
    .InstrM(InstrM), .SrcAM(SrcAM), .SrcBM(SrcBM), .VirtModeW(VirtModeW),
    .HGATP_VMID(HGATP_VMID), .tlb(tlb),
    .FenceStallM(FenceStallM), .FenceDoneM(FenceDoneM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic acks(input logic i, input logic d);
    tlb.ITLBFlushAck = i;
    tlb.DTLBFlushAck = d;
  endtask

  initial begin
    reset = 1'b0; StallM = 1'b0; FlushM = 1'b0;
    sfencevmaM = 1'b0; hfencevvmaM = 1'b0; hfencegvmaM = 1'b0; VirtModeW = 1'b0;
    InstrM = '0; SrcAM = '0; SrcBM = '0; HGATP_VMID = '0;
    acks(1'b0, 1'b0);
    #2;
    chk("rst_stall", FenceStallM, 0);
    chk("rst_done", FenceDoneM, 0);
    chk("rst_ireq", tlb.ITLBFlushReq, 0);
    chk("rst_dreq", tlb.DTLBFlushReq, 0);
    chk("rst_kind", tlb.FlushKind, 0);
    chk("rst_vaddr", tlb.FlushVAddr, 0);
    chk("rst_allasid", tlb.FlushAllAsid, 0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // sfence.vma x5, x0 in M-mode; ITLB acks at +2, DTLB at +4
    sfencevmaM = 1'b1; InstrM = 10'h005; SrcAM = 64'h8000_1000; SrcBM = 64'h7;
    settle();
    chk("t1_c0_stall", FenceStallM, 1);
    chk("t1_c0_ireq", tlb.ITLBFlushReq, 0);
    tick(); settle();
    chk("t1_c1_ireq", tlb.ITLBFlushReq, 1);
    chk("t1_c1_dreq", tlb.DTLBFlushReq, 1);
    chk("t1_c1_stall", FenceStallM, 1);
    chk("t1_kind", tlb.FlushKind, 2'b00);
    chk("t1_vaddr", tlb.FlushVAddr, 64'h8000_1000);
    chk("t1_alladdr", tlb.FlushAllAddr, 0);
    chk("t1_allasid", tlb.FlushAllAsid, 1);
    chk("t1_asid", tlb.FlushAsid, 16'h0007);
    chk("t1_vmid", tlb.FlushVmid, 0);
    tick(); acks(1'b1, 1'b0); settle();
    chk("t1_c2_ireq", tlb.ITLBFlushReq, 1);
    chk("t1_c2_stall", FenceStallM, 1);
    tick(); acks(1'b0, 1'b0); settle();
    chk("t1_c3_ireq", tlb.ITLBFlushReq, 0);
    chk("t1_c3_dreq", tlb.DTLBFlushReq, 1);
    chk("t1_c3_stall", FenceStallM, 1);
    tick(); acks(1'b0, 1'b1); settle();
    chk("t1_c4_dreq", tlb.DTLBFlushReq, 1);
    chk("t1_c4_stall", FenceStallM, 1);
    chk("t1_c4_done", FenceDoneM, 0);
    tick(); acks(1'b0, 1'b0); settle();
    chk("t1_c5_stall", FenceStallM, 0);
    chk("t1_c5_done", FenceDoneM, 1);
    chk("t1_c5_dreq", tlb.DTLBFlushReq, 0);
    tick(); sfencevmaM = 1'b0; settle();
    chk("t1_c6_done", FenceDoneM, 0);
    chk("t1_c6_stall", FenceStallM, 0);

    // hfence.gvma, VMID 0x2A, both acks in the same WAIT cycle
    hfencegvmaM = 1'b1; InstrM = 10'h0C7; SrcAM = 64'h1234; SrcBM = 64'h2A;
    settle();
    chk("t2_c0_stall", FenceStallM, 1);
    tick(); settle();
    chk("t2_kind", tlb.FlushKind, 2'b10);
    chk("t2_vmid", tlb.FlushVmid, 14'h2A);
    chk("t2_asid", tlb.FlushAsid, 16'h002A);
    chk("t2_allasid", tlb.FlushAllAsid, 0);
    chk("t2_alladdr", tlb.FlushAllAddr, 0);
    chk("t2_vaddr", tlb.FlushVAddr, 64'h1234);
    tick(); acks(1'b1, 1'b1); settle();
    chk("t2_c2_ireq", tlb.ITLBFlushReq, 1);
    chk("t2_c2_dreq", tlb.DTLBFlushReq, 1);
    tick(); acks(1'b0, 1'b0); settle();
    chk("t2_c3_ireq", tlb.ITLBFlushReq, 0);
    chk("t2_c3_dreq", tlb.DTLBFlushReq, 0);
    chk("t2_c3_done", FenceDoneM, 1);
    chk("t2_c3_stall", FenceStallM, 0);
    tick(); hfencegvmaM = 1'b0; settle();
    chk("t2_c4_done", FenceDoneM, 0);

    // sfence in VS mode, rs1=x0, acks in REQ, then StallM held 4 DONE cycles
    sfencevmaM = 1'b1; VirtModeW = 1'b1; HGATP_VMID = 14'd3; InstrM = 10'h120;
    SrcAM = 64'hDEAD; SrcBM = 64'h5;
    settle();
    tick(); acks(1'b1, 1'b1); settle();
    chk("t3_kind", tlb.FlushKind, 2'b01);
    chk("t3_vmid", tlb.FlushVmid, 14'd3);
    chk("t3_alladdr", tlb.FlushAllAddr, 1);
    chk("t3_allasid", tlb.FlushAllAsid, 0);
    chk("t3_c1_ireq", tlb.ITLBFlushReq, 1);
    tick(); acks(1'b0, 1'b0); StallM = 1'b1; settle();
    chk("t3_c2_ireq", tlb.ITLBFlushReq, 0);
    chk("t3_c2_dreq", tlb.DTLBFlushReq, 0);
    chk("t3_c2_stall", FenceStallM, 1);
    chk("t3_c2_done", FenceDoneM, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      chk($sformatf("t3_held_done%0d", i), FenceDoneM, 1);
      chk($sformatf("t3_held_stall%0d", i), FenceStallM, 0);
    end
    tick(); StallM = 1'b0; settle();
    chk("t3_release_done", FenceDoneM, 1);
    tick(); sfencevmaM = 1'b0; VirtModeW = 1'b0; settle();
    chk("t3_idle_done", FenceDoneM, 0);
    chk("t3_idle_stall", FenceStallM, 0);

    // FlushM during WAIT: handshake completes, no done
    sfencevmaM = 1'b1; InstrM = 10'h005; SrcAM = 64'h40;
    settle();
    tick(); settle();
    chk("t4_c1_ireq", tlb.ITLBFlushReq, 1);
    tick(); FlushM = 1'b1; sfencevmaM = 1'b0; settle();
    chk("t4_c2_stall", FenceStallM, 1);
    chk("t4_c2_dreq", tlb.DTLBFlushReq, 1);
    tick(); FlushM = 1'b0; acks(1'b1, 1'b0); settle();
    chk("t4_c3_ireq", tlb.ITLBFlushReq, 1);
    chk("t4_c3_dreq", tlb.DTLBFlushReq, 1);
    chk("t4_c3_done", FenceDoneM, 0);
    tick(); acks(1'b0, 1'b1); settle();
    chk("t4_c4_ireq", tlb.ITLBFlushReq, 0);
    chk("t4_c4_dreq", tlb.DTLBFlushReq, 1);
    chk("t4_c4_done", FenceDoneM, 0);
    tick(); acks(1'b0, 1'b0); settle();
    chk("t4_c5_done", FenceDoneM, 0);
    chk("t4_c5_stall", FenceStallM, 0);
    chk("t4_c5_dreq", tlb.DTLBFlushReq, 0);
    tick(); settle();
    chk("t4_c6_done", FenceDoneM, 0);

    // asynchronous reset in WAIT, then a late ack in IDLE
    sfencevmaM = 1'b1; SrcAM = 64'h55;
    settle();
    tick(); settle();
    tick(); settle();
    chk("t5_wait_ireq", tlb.ITLBFlushReq, 1);
    reset = 1'b0; sfencevmaM = 1'b0;
    settle();
    chk("t5_rst_ireq", tlb.ITLBFlushReq, 0);
    chk("t5_rst_dreq", tlb.DTLBFlushReq, 0);
    chk("t5_rst_stall", FenceStallM, 0);
    chk("t5_rst_done", FenceDoneM, 0);
    chk("t5_rst_vaddr", tlb.FlushVAddr, 0);
    tick(); reset = 1'b1; acks(1'b1, 1'b1); settle();
    tick(); acks(1'b0, 1'b0); settle();
    chk("t5_late_ireq", tlb.ITLBFlushReq, 0);
    chk("t5_late_dreq", tlb.DTLBFlushReq, 0);
    chk("t5_late_done", FenceDoneM, 0);
    chk("t5_late_stall", FenceStallM, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
